data_mem_responder: RTL and testbench

- Data-memory slave for the multi-cycle CPU datapath; it answers the control unit's memory strobes (mRD/mWR) issued in the MEM state.
- Turns level strobes into a registered, wait-stated access with a one-cycle mReady completion pulse.
- Reports misaligned, out-of-range and conflicting requests on mErr.
- Lets the CPU stall the MEM state until mReady, instead of relying on zero-latency combinational memory.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/dmem_byte_array.sv | 41 ++++
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  // Controller states; the encoding is visible to anything that probes the state register.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10,
    HOLD = 2'b11
  } state_e;

  // Latched operation, taken directly from {mWR, mRD} at capture; OP_RW flags a conflict.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

  // True when a word access at addr is aligned and fits entirely inside the storage.
  // The full 32 bits are compared, so large addresses never wrap into range.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth_bytes);
    return (addr[1:0] == 2'b00) && (addr <= 32'(depth_bytes - 4));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory strobe/handshake bundle between the CPU datapath and the data-memory responder.
interface data_mem_responder_if;
  logic        mRD;
  logic        mWR;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        mReady;
  logic        mErr;
  logic        busy;

  modport master (
    output mRD, mWR, DAddr, DataIn,
    input  DataOut, mReady, mErr, busy
  );

  modport slave (
    input  mRD, mWR, DAddr, DataIn,
    output DataOut, mReady, mErr, busy
  );
endinterface

// File: rtl/dmem_byte_array.sv
// Byte-lane storage with one big-endian 32-bit word port and a registered read word.
// Storage is not reset; only the read register is.
module dmem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 128,
  localparam int unsigned WordAw = $clog2(DEPTH_BYTES / 4)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [WordAw-1:0] waddr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  // Word write: byte[a] takes the most significant lane.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[{waddr, 2'b00}] <= wdata[31:24];
      mem[{waddr, 2'b01}] <= wdata[23:16];
      mem[{waddr, 2'b10}] <= wdata[15:8];
      mem[{waddr, 2'b11}] <= wdata[7:0];
    end
  end

  // Read register: cleared on reset or on an error response, else loaded on a read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdata <= 32'h0;
    end else if (rd_clr) begin
      rdata <= 32'h0;
    end else if (rd_en) begin
      rdata <= {mem[{waddr, 2'b00}], mem[{waddr, 2'b01}],
                mem[{waddr, 2'b10}], mem[{waddr, 2'b11}]};
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data-memory slave: captures a level strobe, waits WAIT_CYCLES, performs one
// access and answers with a single-cycle mReady (plus mErr for rejected requests).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 CLK,
  input logic                 RST,
  data_mem_responder_if.slave bus
);

  localparam int unsigned CntW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned WordAw = $clog2(DEPTH_BYTES / 4);
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  logic              req;
  logic              acc_go;
  op_e               acc_op;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_data;
  logic              acc_err;
  logic              ram_we;
  logic              ram_rd;
  logic              ram_clr;
  logic [31:0]       ram_rdata;

  assign req = bus.mRD | bus.mWR;

  // State, wait counter, latched request and error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next state, request capture and selection of the access to perform this edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    acc_go   = 1'b0;
    acc_op   = op_q;
    acc_addr = addr_q;
    acc_data = data_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          op_d   = op_e'({bus.mWR, bus.mRD});
          addr_d = bus.DAddr;
          data_d = bus.DataIn;
          cnt_d  = CntLoad;
          if (WAIT_CYCLES == 0) begin
            // No wait states: access straight from the bus at the capture edge.
            acc_go   = 1'b1;
            acc_op   = op_e'({bus.mWR, bus.mRD});
            acc_addr = bus.DAddr;
            acc_data = bus.DataIn;
            state_d  = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          acc_go  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = req ? HOLD : IDLE;
      end
      HOLD: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    acc_err = !addr_ok(acc_addr, DEPTH_BYTES) || (acc_op == OP_RW);
    ram_we  = acc_go && !acc_err && (acc_op == OP_WR);
    ram_rd  = acc_go && !acc_err && (acc_op == OP_RD);
    ram_clr = acc_go && acc_err;
    if (acc_go) begin
      err_d = acc_err;
    end
  end

  dmem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_ram (
    .CLK    (CLK),
    .RST    (RST),
    .we     (ram_we),
    .rd_en  (ram_rd),
    .rd_clr (ram_clr),
    .waddr  (acc_addr[WordAw+1:2]),
    .wdata  (acc_data),
    .rdata  (ram_rdata)
  );

  assign bus.DataOut = ram_rdata;
  assign bus.mReady  = (state_q == RESP);
  assign bus.mErr    = err_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, hand-written corner cases and
// randomized traffic against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int unsigned W     = 2;
  localparam int unsigned DEPTH = 128;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  data_mem_responder_if bi ();
  data_mem_responder_if bz ();

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bi)
  );

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bz)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference state: byte memory and last expected DataOut of the W-cycle instance.
  logic [7:0]  mem_m [DEPTH];
  logic [31:0] dout_m;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Transaction-level effect of one request on memory and DataOut.
  task automatic model(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output bit e);
    e = (a[1:0] != 2'b00) || (a > 32'(DEPTH - 4)) || (rd && wr);
    if (e) begin
      dout_m = 32'h0;
    end else if (wr) begin
      for (int k = 0; k < 4; k++) mem_m[a + k] = d[31 - 8 * k -: 8];
    end else begin
      dout_m = {mem_m[a], mem_m[a + 1], mem_m[a + 2], mem_m[a + 3]};
    end
  endtask

  // One handshake on the W-cycle instance; called at a negedge with the DUT idle.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit perturb, input int hold, output logic [31:0] dout,
                        output bit err, output int first_busy);
    bit e_exp;
    int lat;
    model(rd, wr, a, d, e_exp);
    bi.mRD = rd;
    bi.mWR = wr;
    bi.DAddr = a;
    bi.DataIn = d;
    lat = -1;
    first_busy = -1;
    dout = 32'h0;
    err = 1'b0;
    for (int n = 1; n <= int'(W) + 10; n++) begin
      @(negedge CLK);
      if (perturb && n == 1) begin
        bi.DAddr = a ^ 32'h0000_0018;
        bi.DataIn = ~d;
      end
      check("busy_active", bi.busy, 1);
      if (first_busy < 0 && bi.busy) first_busy = cyc;
      if (bi.mReady) begin
        lat = n;
        dout = bi.DataOut;
        err = bi.mErr;
        break;
      end
    end
    check("latency", lat, 1 + W);
    if (lat >= 0) begin
      check("m_err", err, e_exp);
      check("data_out", dout, dout_m);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check("hold_busy", bi.busy, 1);
      check("hold_no_ready", bi.mReady, 0);
    end
    bi.mRD = 1'b0;
    bi.mWR = 1'b0;
    @(negedge CLK);
    check("idle_busy", bi.busy, 0);
    check("idle_err", bi.mErr, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dout;
    bit          err;
    int          fb1, fb2;

    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 8'h00;
    dout_m = 32'h0;
    bi.mRD = 0; bi.mWR = 0; bi.DAddr = 0; bi.DataIn = 0;
    bz.mRD = 0; bz.mWR = 0; bz.DAddr = 0; bz.DataIn = 0;

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_007C, 32'h1122_3344, 1'b0, 32'h0000_0000};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0080, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h0000_0000, 1'b0, 32'h1122_3344};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h5566_7788, 1'b0, 32'h1122_3344};
    tbl[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h5566_7788};
    tbl[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_000D, 32'h0BAD_0BAD, 1'b1, 32'h0000_0000};

    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_ready", bi.mReady, 0);
    check("rst_err", bi.mErr, 0);
    check("rst_busy", bi.busy, 0);
    check("rst_dout", bi.DataOut, 0);
    check("rst0_busy", bz.busy, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      do_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0, 0, dout, err, fb1);
      check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
    end
    check("peek_08", dut.u_ram.mem[8], 8'hDE);

    // Zero wait states: single response per level, then a fresh request is accepted.
    bz.mRD = 1'b1;
    bz.DAddr = 32'h0;
    @(negedge CLK);
    check("zw_ready", bz.mReady, 1);
    check("zw_err", bz.mErr, 0);
    check("zw_busy", bz.busy, 1);
    repeat (3) begin
      @(negedge CLK);
      check("zw_hold_ready", bz.mReady, 0);
      check("zw_hold_busy", bz.busy, 1);
    end
    bz.mRD = 1'b0;
    @(negedge CLK);
    check("zw_idle_busy", bz.busy, 0);
    bz.mWR = 1'b1;
    bz.DAddr = 32'h4;
    bz.DataIn = 32'h0BAD_F00D;
    @(negedge CLK);
    check("zw_wr_ready", bz.mReady, 1);
    check("zw_wr_err", bz.mErr, 0);
    bz.mWR = 1'b0;
    @(negedge CLK);
    bz.mRD = 1'b1;
    @(negedge CLK);
    check("zw_rd_ready", bz.mReady, 1);
    check("zw_rd_dout", bz.DataOut, 32'h0BAD_F00D);
    bz.mRD = 1'b0;
    @(negedge CLK);

    // Address/data changes after capture are ignored.
    do_req(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b0, 0, dout, err, fb1);
    do_req(1'b0, 1'b1, 32'h34, 32'h0102_0304, 1'b1, 0, dout, err, fb1);
    do_req(1'b1, 1'b0, 32'h34, 32'h0, 1'b1, 0, dout, err, fb1);
    check("stab_wr_rd", dout, 32'h0102_0304);
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 0, dout, err, fb1);
    check("stab_rd", dout, 32'hCAFE_F00D);

    // Reset during WAIT aborts a write.
    do_req(1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5, 1'b0, 0, dout, err, fb1);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 0, dout, err, fb1);
    bi.mWR = 1'b1;
    bi.DAddr = 32'h10;
    bi.DataIn = 32'h1234_5678;
    @(negedge CLK);
    check("abort_wait_busy", bi.busy, 1);
    RST = 1'b1;
    #1;
    check("abort_dout", bi.DataOut, 0);
    check("abort_busy", bi.busy, 0);
    check("abort_ready", bi.mReady, 0);
    check("abort_err", bi.mErr, 0);
    dout_m = 32'h0;
    bi.mWR = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      check("abort_rst_ready", bi.mReady, 0);
      check("abort_rst_err", bi.mErr, 0);
    end
    RST = 1'b0;
    @(negedge CLK);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 0, dout, err, fb1);
    check("abort_old_value", dout, 32'hA5A5_A5A5);

    // Back-to-back writes from an initiator that drops its strobe one cycle after mReady.
    do_req(1'b0, 1'b1, 32'h40, 32'h1111_2222, 1'b0, 1, dout, err, fb1);
    do_req(1'b0, 1'b1, 32'h44, 32'h3333_4444, 1'b0, 1, dout, err, fb2);
    checks++;
    if (fb1 < 0 || fb2 < 0 || (fb2 - fb1) < int'(W) + 3) begin
      errors++;
      $display("FAIL spacing: got %0d cycles, required at least %0d", fb2 - fb1, W + 3);
    end

    // Fill every word, then random traffic.
    for (int w = 0; w < int'(DEPTH) / 4; w++) begin
      do_req(1'b0, 1'b1, 32'(4 * w), $urandom(), 1'b0, 0, dout, err, fb1);
    end
    for (int t = 0; t < 200; t++) begin
      int unsigned kind, ak;
      bit rd, wr;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      rd = (kind == 0) || (kind >= 5);
      wr = (kind <= 4);
      ak = $urandom_range(0, 9);
      if (ak < 7) a = 32'(4 * $urandom_range(0, DEPTH / 4 - 1));
      else if (ak == 7) a = 32'(4 * $urandom_range(0, DEPTH / 4 - 1) + $urandom_range(1, 3));
      else if (ak == 8) a = 32'(DEPTH + 4 * $urandom_range(0, 15));
      else a = $urandom() | 32'h8000_0000;
      do_req(rd, wr, a, $urandom(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
             dout, err, fb1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
